regfile_wb_arbiter: RTL
=======================

Name: regfile_wb_arbiter

Overview:
- Shares the single register-file write port among NUM_REQ write-back sources, e.g. ALU, load unit and multiplier.
- Uses a round-robin grant and presents the winner as a registered write (wr_en/wr_addr/wr_data) to the register bank one cycle later.
- Sits between the execute/memory stages and the register file.
- Provides a stall input so the register side can freeze write-back.

Parameters:
- WIDTH, 32, data width of one register.
- NUM_REQ, 3, number of write-back requesters; legal range 2..8.
- AW, 4, register address width (16 architectural registers; r15 = PC).

Ports:
- clk  input  1  system clock; all state updates on posedge clk.
- rst  input  1  synchronous, active-high reset, sampled on posedge clk.
- wb_stall  input  1  1 = register side cannot accept a write this cycle.
- req_valid  input  NUM_REQ  bit i = requester i has a pending write.
- req_addr  input  NUM_REQ*AW  requester i address in bits [i*AW +: AW].
- req_data  input  NUM_REQ*WIDTH  requester i data in bits [i*WIDTH +: WIDTH].
- req_ready  output  NUM_REQ  one-hot or zero; bit i = requester i granted this cycle.
- wr_en  output  1  registered write strobe to the register file.
- wr_addr  output  AW  registered write address.
- wr_data  output  WIDTH  registered write data.
- grant_cnt  output  16  number of completed grants since reset; wraps.

Behaviour:
- Reset: synchronous, active-high; clock and reset ports are clk and rst.
  - On a clk edge with rst=1: wr_en=0, wr_addr=0, wr_data=0, grant_cnt=0, pointer ptr=0.
  - req_ready is combinational and is all-zero while rst=1.
  - Reset mid-transfer: any grant in that cycle is discarded and no write is issued.
- Handshake: a transfer occurs when req_valid[i] & req_ready[i] in the same cycle.
  - A requester holds valid, addr and data stable until accepted.
  - req_ready[i] is never 1 while req_valid[i]=0.
- Grant (combinational):
  - If wb_stall=1 or no valid requests: req_ready=0.
  - Otherwise grant the first valid index scanning ptr, ptr+1, ... modulo NUM_REQ.
  - Exactly one grant per cycle.
- Pointer:
  - On a grant to i: ptr <= (i+1) mod NUM_REQ.
  - With no grant, ptr holds.
- Output register, 1-cycle latency from acceptance:
  - On a grant: wr_en<=1, wr_addr<=req_addr[i], wr_data<=req_data[i].
  - On no grant (including stall): wr_en<=0; wr_addr/wr_data hold their previous values.
- Stall: while wb_stall=1 there are no grants, wr_en deasserts next edge, and ptr and grant_cnt hold.
  - A write already registered (wr_en=1) in the cycle stall rises is considered delivered; the register file must absorb it.
- grant_cnt: +1 per grant, mod 2^16 (0xFFFF -> 0x0000).
- Same-address collisions: requests from different requesters to the same register are serialized in grant order; the later grant overwrites. The arbiter does no merging.
- Back-to-back: one write per cycle is sustained with no bubbles while requests are present and wb_stall=0.

Optional Feature:
- Macro: RF_ARB_R15_PRIORITY_EN.
- Defined:
  - Any valid request with addr == 4'hF (PC write) wins over round-robin order.
  - If several target r15, the lowest index wins.
  - ptr still updates to winner+1.
- Undefined: r15 writes are arbitrated like any other address; there is no priority logic.

Test Plan:
- Reset: assert rst for 2 cycles with all req_valid=3'b111 -> req_ready=0, wr_en=0, grant_cnt=0. First cycle after release grants requester 0.
- Round-robin: req_valid held at 3'b111, each request re-presented after acceptance, for 6 cycles -> grants 0,1,2,0,1,2, one per cycle; wr_en=1 from cycle 2 on; grant_cnt=6.
- Single requester with data: req_valid=3'b100, addr=5, data=0xDEADBEEF -> req_ready=3'b100 same cycle; next cycle wr_en=1, wr_addr=5, wr_data=0xDEADBEEF.
- Stall: wb_stall=1 for 3 cycles with req_valid=3'b011 -> req_ready=0 and wr_en=0 after the first edge; ptr unchanged. On release, the requester at ptr is granted first.
- Counter wrap: preload 0xFFFF grants (or force), then one grant -> grant_cnt=0x0000.
- r15 priority (macro defined), ptr=0, req_valid=3'b011, req1 addr=15 -> requester 1 granted first, then requester 0. With the macro undefined -> requester 0 granted first.

Source files
------------

// File: rtl/regfile_wb_arbiter.sv
// Round-robin arbiter that shares the register-file write port among NUM_REQ write-back sources.
// Optional macro RF_ARB_R15_PRIORITY_EN lets any request targeting r15 (PC) win over round-robin order.
module regfile_wb_arbiter #(
   parameter int WIDTH   = 32,
   parameter int NUM_REQ = 3,
   parameter int AW      = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     wb_stall,
   input  logic [NUM_REQ-1:0]       req_valid,
   input  logic [NUM_REQ*AW-1:0]    req_addr,
   input  logic [NUM_REQ*WIDTH-1:0] req_data,
   output logic [NUM_REQ-1:0]       req_ready,
   output logic                     wr_en,
   output logic [AW-1:0]            wr_addr,
   output logic [WIDTH-1:0]         wr_data,
   output logic [15:0]              grant_cnt
);

   localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

   generate
      if (NUM_REQ < 2 || NUM_REQ > 8) begin : g_bad_num_req
         $error("regfile_wb_arbiter: NUM_REQ must be in 2..8");
      end
   endgenerate

   logic [PW-1:0]    ptr;
   logic [PW-1:0]    win_idx;
   logic             any_grant;
   logic [AW-1:0]    addr_arr [NUM_REQ];
   logic [WIDTH-1:0] data_arr [NUM_REQ];

   genvar g;
   generate
      for (g = 0; g < NUM_REQ; g++) begin : g_unpack
         assign addr_arr[g] = req_addr[g*AW +: AW];
         assign data_arr[g] = req_data[g*WIDTH +: WIDTH];
      end
   endgenerate

   // (base + off) mod NUM_REQ; off never exceeds NUM_REQ so one subtraction suffices.
   function automatic logic [PW-1:0] wrap_idx(input logic [PW-1:0] base, input int off);
      int s;
      s = int'(base) + off;
      if (s >= NUM_REQ) s = s - NUM_REQ;
      return s[PW-1:0];
   endfunction

`ifdef RF_ARB_R15_PRIORITY_EN
   localparam logic [AW-1:0] PC_ADDR = AW'(15);
`endif

   // Scan from the far end so the last hit written is the one closest to ptr.
   always_comb begin
      any_grant = 1'b0;
      win_idx   = '0;
      if (!rst && !wb_stall) begin
         for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (req_valid[wrap_idx(ptr, k)]) begin
               any_grant = 1'b1;
               win_idx   = wrap_idx(ptr, k);
            end
         end
`ifdef RF_ARB_R15_PRIORITY_EN
         for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (req_valid[i] && addr_arr[i] == PC_ADDR) begin
               win_idx = PW'(i);
            end
         end
`endif
      end
   end

   always_comb begin
      req_ready = '0;
      if (any_grant) req_ready[win_idx] = 1'b1;
   end

   // Address and data hold on idle cycles so the register side sees a stable bus.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_en     <= 1'b0;
         wr_addr   <= '0;
         wr_data   <= '0;
         grant_cnt <= '0;
         ptr       <= '0;
      end else begin
         wr_en <= any_grant;
         if (any_grant) begin
            wr_addr   <= addr_arr[win_idx];
            wr_data   <= data_arr[win_idx];
            grant_cnt <= grant_cnt + 16'd1;
            ptr       <= wrap_idx(win_idx, 1);
         end
      end
   end

endmodule
